// File: rtl/frame_draw_scheduler.sv
// Frame sequencer: runs the background drawer, then each active sprite
// drawer, and routes the owning client onto the shared VGA write port.
module frame_draw_scheduler #(
    parameter int NUM_SPR     = 2,
    parameter int COLOR_DEPTH = 9,
    parameter int OFFSET_W    = 7,
    parameter int TIMEOUT     = 8192,
    parameter int TMR_W       = 14
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic [OFFSET_W-1:0]          scroll_offset,
    output logic                         bg_enable,
    output logic [OFFSET_W-1:0]          bg_x_offset,
    input  logic                         bg_done,
    input  logic [7:0]                   bg_x,
    input  logic [6:0]                   bg_y,
    input  logic [COLOR_DEPTH-1:0]       bg_color,
    input  logic                         bg_plot,
    input  logic [NUM_SPR-1:0]           spr_active,
    output logic [NUM_SPR-1:0]           spr_enable,
    input  logic [NUM_SPR-1:0]           spr_done,
    input  logic [NUM_SPR*8-1:0]         spr_x,
    input  logic [NUM_SPR*7-1:0]         spr_y,
    input  logic [NUM_SPR*COLOR_DEPTH-1:0] spr_color,
    input  logic [NUM_SPR-1:0]           spr_plot,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [COLOR_DEPTH-1:0]       vga_color,
    output logic                         vga_plot,
    output logic                         busy,
    output logic                         overrun,
    output logic                         timeout_err
);

    localparam int IW = $clog2(NUM_SPR + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BG_START   = 3'd1;
    localparam logic [2:0] S_BG_RUN     = 3'd2;
    localparam logic [2:0] S_SPR_SEL    = 3'd3;
    localparam logic [2:0] S_SPR_START  = 3'd4;
    localparam logic [2:0] S_SPR_RUN    = 3'd5;
    localparam logic [2:0] S_FRAME_DONE = 3'd6;

    logic [2:0]             state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [TMR_W-1:0]       wd;
    logic                   pending;
    logic                   in_bg, in_spr, tmo, start;
    logic                   cur_act;
    logic                   sel_done, sel_plot;
    logic [7:0]             sel_x;
    logic [6:0]             sel_y;
    logic [COLOR_DEPTH-1:0] sel_color;

    assign in_bg  = (state == S_BG_START) || (state == S_BG_RUN);
    assign in_spr = (state == S_SPR_START) || (state == S_SPR_RUN);
    assign tmo    = (in_bg || in_spr) && (wd == TMR_W'(TIMEOUT));
    assign start  = frame_tick || pending;
    assign busy   = (state != S_IDLE) && (state != S_FRAME_DONE);

    assign bg_enable = (state == S_BG_START) && !tmo;

    always_comb begin
        spr_enable = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (state == S_SPR_START && idx == IW'(i) && !tmo)
                spr_enable[i] = 1'b1;
        end
    end

    // Client mux: background by default, the indexed sprite while it owns the port.
    always_comb begin
        cur_act   = 1'b0;
        sel_done  = bg_done;
        sel_plot  = bg_plot;
        sel_x     = bg_x;
        sel_y     = bg_y;
        sel_color = bg_color;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (idx == IW'(i)) begin
                cur_act = spr_active[i];
                if (in_spr) begin
                    sel_done  = spr_done[i];
                    sel_plot  = spr_plot[i];
                    sel_x     = spr_x[i*8 +: 8];
                    sel_y     = spr_y[i*7 +: 7];
                    sel_color = spr_color[i*COLOR_DEPTH +: COLOR_DEPTH];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE:
                if (start) state_n = S_BG_START;
            S_BG_START:
                if (tmo) begin
                    state_n = S_SPR_SEL;
                    idx_n   = '0;
                end else if (!bg_done) begin
                    state_n = S_BG_RUN;
                end
            S_BG_RUN:
                if (tmo || bg_done) begin
                    state_n = S_SPR_SEL;
                    idx_n   = '0;
                end
            S_SPR_SEL:
                if (idx == IW'(NUM_SPR)) state_n = S_FRAME_DONE;
                else if (cur_act)        state_n = S_SPR_START;
                else                     idx_n   = idx + IW'(1);
            S_SPR_START:
                if (tmo) begin
                    state_n = S_SPR_SEL;
                    idx_n   = idx + IW'(1);
                end else if (!sel_done) begin
                    state_n = S_SPR_RUN;
                end
            S_SPR_RUN:
                if (tmo || sel_done) begin
                    state_n = S_SPR_SEL;
                    idx_n   = idx + IW'(1);
                end
            S_FRAME_DONE:
                state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            wd          <= '0;
            pending     <= 1'b0;
            bg_x_offset <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            vga_plot    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_color   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if ((state_n == S_BG_START && state != S_BG_START) ||
                (state_n == S_SPR_START && state != S_SPR_START))
                wd <= '0;
            else if (in_bg || in_spr)
                wd <= wd + TMR_W'(1);
            // A tick landing in the same IDLE cycle as a pending start stays queued.
            if (state == S_IDLE)
                pending <= pending && frame_tick;
            else if (frame_tick)
                pending <= 1'b1;
            overrun <= frame_tick && pending && (state != S_IDLE);
            if (state == S_IDLE && start)
                bg_x_offset <= scroll_offset;
            if (tmo)
                timeout_err <= 1'b1;
            vga_plot  <= (in_bg || in_spr) && sel_plot;
            vga_x     <= (in_bg || in_spr) ? sel_x : '0;
            vga_y     <= (in_bg || in_spr) ? sel_y : '0;
            vga_color <= (in_bg || in_spr) ? sel_color : '0;
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: behavioural drawer clients, a per-cycle
// reference model of frame ownership, and directed plus random scenarios.
module tb_frame_draw_scheduler;

    localparam int NS = 2;
    localparam int CD = 9;
    localparam int OW = 7;
    localparam int TO = 64;
    localparam int TW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic [OW-1:0] scroll_offset;
    logic          bg_enable;
    logic [OW-1:0] bg_x_offset;
    logic          bg_done;
    logic [7:0]    bg_x;
    logic [6:0]    bg_y;
    logic [CD-1:0] bg_color;
    logic          bg_plot;
    logic [NS-1:0] spr_active;
    logic [NS-1:0] spr_enable;
    logic [NS-1:0] spr_done;
    logic [NS*8-1:0]  spr_x;
    logic [NS*7-1:0]  spr_y;
    logic [NS*CD-1:0] spr_color;
    logic [NS-1:0] spr_plot;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [CD-1:0] vga_color;
    logic          vga_plot;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    always #5 clock = ~clock;

    frame_draw_scheduler #(
        .NUM_SPR(NS), .COLOR_DEPTH(CD), .OFFSET_W(OW),
        .TIMEOUT(TO), .TMR_W(TW)
    ) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .scroll_offset(scroll_offset), .bg_enable(bg_enable),
        .bg_x_offset(bg_x_offset), .bg_done(bg_done), .bg_x(bg_x),
        .bg_y(bg_y), .bg_color(bg_color), .bg_plot(bg_plot),
        .spr_active(spr_active), .spr_enable(spr_enable),
        .spr_done(spr_done), .spr_x(spr_x), .spr_y(spr_y),
        .spr_color(spr_color), .spr_plot(spr_plot), .vga_x(vga_x),
        .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drawer clients: index 0 is background, 1.. are sprites.
    int            ph [3];
    int            cnt[3];
    logic          cd [3];
    logic          cp [3];
    logic [7:0]    cx [3];
    logic [6:0]    cy [3];
    logic [CD-1:0] cc [3];
    logic          c_en[3];
    int            ack_fix, run_fix;
    bit            plot_all, hang_bg;

    always_comb begin
        c_en[0] = bg_enable;
        c_en[1] = spr_enable[0];
        c_en[2] = spr_enable[1];
    end

    assign bg_done   = cd[0];
    assign bg_plot   = cp[0];
    assign bg_x      = cx[0];
    assign bg_y      = cy[0];
    assign bg_color  = cc[0];
    assign spr_done  = {cd[2], cd[1]};
    assign spr_plot  = {cp[2], cp[1]};
    assign spr_x     = {cx[2], cx[1]};
    assign spr_y     = {cy[2], cy[1]};
    assign spr_color = {cc[2], cc[1]};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                ph[k] <= 0; cnt[k] <= 0; cd[k] <= 1'b1; cp[k] <= 1'b0;
                cx[k] <= '0; cy[k] <= '0; cc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                cp[k] <= plot_all ? 1'b1 : 1'($urandom_range(0, 1));
                cx[k] <= 8'($urandom);
                cy[k] <= 7'($urandom);
                cc[k] <= CD'($urandom);
                case (ph[k])
                    0: if (c_en[k]) begin
                        ph[k]  <= 1;
                        cnt[k] <= (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
                    end
                    1: if (cnt[k] == 0) begin
                        cd[k]  <= 1'b0;
                        ph[k]  <= 2;
                        cnt[k] <= (run_fix >= 0) ? run_fix : int'($urandom_range(0, 20));
                    end else cnt[k] <= cnt[k] - 1;
                    default: if (!(hang_bg && k == 0)) begin
                        if (cnt[k] == 0) begin
                            cd[k] <= 1'b1;
                            ph[k] <= 0;
                        end else cnt[k] <= cnt[k] - 1;
                    end
                endcase
            end
        end
    end

    // Reference model: who owns the port, how long, and what is queued.
    int            m_owner, m_age, m_scan;
    bit            m_wait, m_fdone, m_pend, m_err, m_ov, m_vp;
    logic [OW-1:0] m_off;
    logic [7:0]    m_vx;
    logic [6:0]    m_vy;
    logic [CD-1:0] m_vc;
    bit            idle_now, m_tmo, e_bg, fin;
    logic [NS-1:0] e_se;

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_scan = -1; m_wait = 0; m_fdone = 0;
        m_pend = 0; m_err = 0; m_ov = 0; m_vp = 0; m_off = '0;
        m_vx = '0; m_vy = '0; m_vc = '0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            model_reset();
        end else begin
            m_tmo    = (m_owner >= 0) && (m_age == TO);
            idle_now = (m_owner < 0) && (m_scan < 0) && !m_fdone;
            e_bg     = (m_owner == 0) && m_wait && !m_tmo;
            e_se     = '0;
            if (m_owner > 0 && m_wait && !m_tmo) e_se[m_owner-1] = 1'b1;
            chk("bg_enable", 32'(bg_enable), 32'(e_bg));
            chk("spr_enable", 32'(spr_enable), 32'(e_se));
            chk("busy", 32'(busy), 32'(!idle_now && !m_fdone));
            chk("bg_x_offset", 32'(bg_x_offset), 32'(m_off));
            chk("overrun", 32'(overrun), 32'(m_ov));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            chk("vga_plot", 32'(vga_plot), 32'(m_vp));
            chk("vga_x", 32'(vga_x), 32'(m_vx));
            chk("vga_y", 32'(vga_y), 32'(m_vy));
            chk("vga_color", 32'(vga_color), 32'(m_vc));

            m_ov = frame_tick && m_pend && !idle_now;
            if (m_owner >= 0) begin
                m_vp = cp[m_owner]; m_vx = cx[m_owner];
                m_vy = cy[m_owner]; m_vc = cc[m_owner];
            end else begin
                m_vp = 0; m_vx = '0; m_vy = '0; m_vc = '0;
            end
            if (idle_now) begin
                if (frame_tick || m_pend) begin
                    m_owner = 0; m_wait = 1; m_age = 0; m_off = scroll_offset;
                end
                m_pend = m_pend && frame_tick;
            end else begin
                if (frame_tick) m_pend = 1;
                if (m_fdone) begin
                    m_fdone = 0;
                end else if (m_owner < 0) begin
                    if (m_scan == NS) begin
                        m_scan = -1; m_fdone = 1;
                    end else if (spr_active[m_scan]) begin
                        m_owner = m_scan + 1; m_wait = 1; m_age = 0;
                    end else begin
                        m_scan++;
                    end
                end else begin
                    fin = 0;
                    if (m_tmo) begin
                        m_err = 1; fin = 1;
                    end else if (m_wait) begin
                        if (!cd[m_owner]) m_wait = 0;
                    end else if (cd[m_owner]) begin
                        fin = 1;
                    end
                    m_age++;
                    if (fin) begin
                        m_scan = m_owner; m_owner = -1;
                    end
                end
            end
        end
    end

    // Observation counters for the hand-computed expectations.
    int cyc = 0, busy_cnt, ov_cnt, bg_rise, t_bg, t_spr0, t_err;
    int en_seq[$];
    logic p_bg = 0, p_err = 0;
    logic [NS-1:0] p_se = '0;

    task automatic clear_mon();
        busy_cnt = 0; ov_cnt = 0; bg_rise = 0;
        t_bg = -1; t_spr0 = -1; t_err = -1;
        en_seq.delete();
    endtask

    always @(negedge clock) begin
        cyc++;
        if (busy) busy_cnt++;
        if (overrun) ov_cnt++;
        if (bg_enable && !p_bg) begin
            bg_rise++; en_seq.push_back(0);
            if (t_bg < 0) t_bg = cyc;
        end
        for (int i = 0; i < NS; i++)
            if (spr_enable[i] && !p_se[i]) en_seq.push_back(i + 1);
        if (spr_enable[0] && !p_se[0] && t_spr0 < 0) t_spr0 = cyc;
        if (timeout_err && !p_err && t_err < 0) t_err = cyc;
        p_bg = bg_enable; p_se = spr_enable; p_err = timeout_err;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    int n_spr1;
    bit seen;

    initial begin
        reset = 1'b1; frame_tick = 1'b0; scroll_offset = '0; spr_active = '0;
        ack_fix = 2; run_fix = 40; plot_all = 1'b0; hang_bg = 1'b0;
        clear_mon();
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_offset", 32'(bg_x_offset), 0);
        chk("rst_vga_plot", 32'(vga_plot), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b0;
        step();

        // Full frame, every client plotting every cycle, offset moved mid-frame.
        clear_mon();
        plot_all = 1'b1; scroll_offset = 7'd5; spr_active = 2'b11;
        pulse();
        scroll_offset = 7'd9;
        repeat (160) step();
        chk("order_len", 32'(en_seq.size()), 3);
        if (en_seq.size() == 3) begin
            chk("order_0", 32'(en_seq[0]), 0);
            chk("order_1", 32'(en_seq[1]), 1);
            chk("order_2", 32'(en_seq[2]), 2);
        end
        chk("frame1_busy_cycles", 32'(busy_cnt), 141);
        chk("frame1_offset", 32'(bg_x_offset), 5);

        // Sprite 1 inactive.
        clear_mon();
        plot_all = 1'b0; spr_active = 2'b01;
        pulse();
        repeat (120) step();
        n_spr1 = 0;
        foreach (en_seq[i]) if (en_seq[i] == 2) n_spr1++;
        chk("spr1_never_enabled", 32'(n_spr1), 0);
        chk("frame2_busy_cycles", 32'(busy_cnt), 95);

        // Ticks during a busy frame: one queues, the next is dropped.
        clear_mon();
        spr_active = 2'b11;
        pulse();
        repeat (19) step();
        pulse();
        repeat (9) step();
        pulse();
        repeat (400) step();
        chk("overrun_pulses", 32'(ov_cnt), 1);
        chk("frames_started", 32'(bg_rise), 2);

        // Background never finishes: watchdog aborts it, sprites still run.
        clear_mon();
        hang_bg = 1'b1; spr_active = 2'b01;
        pulse();
        repeat (200) step();
        chk("abort_to_err", 32'(t_err - t_bg), 65);
        chk("abort_to_spr0", 32'(t_spr0 - t_bg), 66);
        chk("timeout_err_sticky", 32'(timeout_err), 1);
        hang_bg = 1'b0;
        do_reset();

        // Reset in the middle of a sprite run.
        spr_active = 2'b11;
        pulse();
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (spr_enable[0]) seen = 1;
        end
        chk("spr0_started", 32'(seen), 1);
        repeat (10) step();
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_enables", 32'({bg_enable, spr_enable}), 0);
        chk("midrst_vga", 32'({vga_plot, vga_x, vga_y}), 0);
        chk("midrst_offset", 32'(bg_x_offset), 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        clear_mon();
        pulse();
        step();
        chk("restart_bg", 32'(bg_rise), 1);
        repeat (200) step();

        // Random traffic.
        ack_fix = -1; run_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 29) == 0);
            scroll_offset = OW'($urandom);
            if (frame_tick) spr_active = NS'($urandom);
            step();
        end
        frame_tick = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
